mem_port_arbiter: RTL and testbench
===================================

Name:
mem_port_arbiter

Overview:
Arbitrates one shared memory port between the multicycle CPU's instruction-fetch channel and its data load/store channel. The CPU keeps its two independent valid/ack channel pairs, and this block serialises them onto one request/response memory bus, one transaction at a time, using round-robin arbitration.

Parameters:
ADDR_W, 32, address width on all three sides
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
inst_req_valid  in  1  fetch request; held high until inst_req_ack
inst_addr  in  ADDR_W  fetch address (PC)
inst_req_ack  out  1  fetch request accepted by memory
inst_rdata  out  DATA_W  fetched word (driven from mem_rdata)
inst_rdata_valid  out  1  inst_rdata valid
inst_rdata_ack  in  1  CPU accepts fetched word
data_rd  in  1  load request; held until data_req_ack
data_wr  in  1  store request; held until data_req_ack; wins if data_rd is also high
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_wstrb  in  DATA_W/8  store byte strobes
data_req_ack  out  1  load/store request accepted
data_rdata  out  DATA_W  load data (driven from mem_rdata)
data_rdata_valid  out  1  data_rdata valid
data_rdata_ack  in  1  CPU accepts load data
mem_req_valid  out  1  request to memory
mem_wen  out  1  1 = write, 0 = read; registered
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_wstrb  out  DATA_W/8  registered strobes; 0 for reads
mem_req_ack  in  1  memory accepts request
mem_rdata  in  DATA_W  read data
mem_rdata_valid  in  1  read data valid
mem_rdata_ack  out  1  response accepted, forwarded from the owner's rdata_ack

Behaviour:
- States: IDLE, REQ, RESP. Registers: state, owner (INST/DATA), last (last granted owner), and the mem_wen/addr/wdata/wstrb request registers.
- Reset (rst low, async): state=IDLE, owner=INST, last=DATA, request registers=0, and all valid/ack outputs=0 immediately. An in-flight memory transaction is abandoned; requesters must re-issue.
- IDLE, arbitration:
  - Only one side requesting: grant that side.
  - Both requesting: grant the side != last, so the first tie after reset goes to INST.
  - On grant, at the clock edge: latch the winner's addr/wdata/wstrb/wen, set owner and last, go to REQ.
  - INST grants use wen=0, wstrb=0, wdata=0.
  - No request: stay in IDLE.
- REQ:
  - mem_req_valid=1.
  - Owner's req_ack = mem_req_ack (combinational); the other side's req_ack=0.
  - On mem_req_ack: a write goes to IDLE, a read goes to RESP.
  - Minimum latency is one cycle from request to mem_req_valid.
- RESP:
  - Owner's rdata_valid = mem_rdata_valid; mem_rdata_ack = owner's rdata_ack (both combinational).
  - On mem_rdata_valid & owner's rdata_ack: go to IDLE.
  - The non-owner's rdata_valid stays 0.
- Requests arriving during REQ/RESP wait; requesters hold them and they are arbitrated on return to IDLE. No back-to-back grant on the same edge as completion, so there is one IDLE cycle minimum between transactions.
- mem_req_valid=0 and mem_rdata_ack=0 outside REQ and RESP respectively.
- Spurious mem_rdata_valid outside RESP is ignored: no ack, no forwarding.
- inst_rdata and data_rdata both equal mem_rdata at all times; only the valid strobes qualify them.
- Requesters changing request fields after a grant do not affect the latched registers.

Test Plan:
- Fetch only: inst_req_valid=1, inst_addr=0x40, mem acks after 2 cycles, rdata=0x8C010004 -> mem_addr=0x40, mem_wen=0; inst_rdata_valid=1 with 0x8C010004; data_rdata_valid stays 0; state returns to IDLE.
- Store: data_wr=1, addr=0x104, wdata=0xDEADBEEF, wstrb=4'b0011 -> mem_wen=1 and fields registered; data_req_ack pulses with mem_req_ack; no RESP phase.
- Tie after reset: inst and data request on the same cycle -> INST granted first, DATA granted on the next IDLE; a third tie goes to INST again.
- Load with memory and response stalls: mem_rdata_valid high 3 cycles while data_rdata_ack=0 -> mem_rdata_ack=0 and state held; ack on cycle 4 -> IDLE.
- Reset mid-RESP: rst low during RESP -> mem_req_valid, mem_rdata_ack and all valids go 0 immediately; after release, a fetch to 0x0 completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU fetch/data channels and shared memory bus bundle
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch channel
  logic                inst_req_valid;
  logic [ADDR_W-1:0]   inst_addr;
  logic                inst_req_ack;
  logic [DATA_W-1:0]   inst_rdata;
  logic                inst_rdata_valid;
  logic                inst_rdata_ack;
  // data load/store channel
  logic                data_rd;
  logic                data_wr;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic [DATA_W/8-1:0] data_wstrb;
  logic                data_req_ack;
  logic [DATA_W-1:0]   data_rdata;
  logic                data_rdata_valid;
  logic                data_rdata_ack;
  // shared memory port
  logic                mem_req_valid;
  logic                mem_wen;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_req_ack;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_rdata_valid;
  logic                mem_rdata_ack;

  // arbiter side
  modport slave (
    input  inst_req_valid, inst_addr, inst_rdata_ack,
    output inst_req_ack, inst_rdata, inst_rdata_valid,
    input  data_rd, data_wr, data_addr, data_wdata, data_wstrb, data_rdata_ack,
    output data_req_ack, data_rdata, data_rdata_valid,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb, mem_rdata_ack,
    input  mem_req_ack, mem_rdata, mem_rdata_valid
  );

  // CPU plus memory side
  modport master (
    output inst_req_valid, inst_addr, inst_rdata_ack,
    input  inst_req_ack, inst_rdata, inst_rdata_valid,
    output data_rd, data_wr, data_addr, data_wdata, data_wstrb, data_rdata_ack,
    input  data_req_ack, data_rdata, data_rdata_valid,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb, mem_rdata_ack,
    output mem_req_ack, mem_rdata, mem_rdata_valid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter of CPU fetch and data channels onto one memory port
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic                last;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic inst_want;
  logic data_want;
  logic grant;
  logic grant_data;
  logic owner_rdata_ack;

  logic inst_req_ack;
  logic data_req_ack;
  logic inst_rdata_valid;
  logic data_rdata_valid;
  logic mem_req_valid;
  logic mem_rdata_ack;

  assign inst_want = bus.inst_req_valid;
  assign data_want = bus.data_rd | bus.data_wr;
  assign grant     = inst_want | data_want;
  // On a tie the side that did not win last time takes the port.
  assign grant_data = data_want & (~inst_want | (last == INST));
  assign owner_rdata_ack = (owner == DATA) ? bus.data_rdata_ack : bus.inst_rdata_ack;

  // State register; asynchronous clear abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Latch winner's request fields and ownership at the grant edge only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner   <= INST;
      last    <= DATA;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state == IDLE && grant) begin
      owner <= grant_data;
      last  <= grant_data;
      if (grant_data) begin
        wen_q   <= bus.data_wr;
        addr_q  <= bus.data_addr;
        wdata_q <= bus.data_wdata;
        wstrb_q <= bus.data_wr ? bus.data_wstrb : '0;
      end else begin
        wen_q   <= 1'b0;
        addr_q  <= bus.inst_addr;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

  // Next state: writes finish on request accept, reads after the response handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = REQ;
      REQ:     if (bus.mem_req_ack) state_nxt = wen_q ? IDLE : RESP;
      RESP:    if (bus.mem_rdata_valid && owner_rdata_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs routed only to/from the current owner
  always_comb begin
    mem_req_valid    = 1'b0;
    mem_rdata_ack    = 1'b0;
    inst_req_ack     = 1'b0;
    data_req_ack     = 1'b0;
    inst_rdata_valid = 1'b0;
    data_rdata_valid = 1'b0;
    case (state)
      REQ: begin
        mem_req_valid = 1'b1;
        inst_req_ack  = (owner == INST) & bus.mem_req_ack;
        data_req_ack  = (owner == DATA) & bus.mem_req_ack;
      end
      RESP: begin
        mem_rdata_ack    = owner_rdata_ack;
        inst_rdata_valid = (owner == INST) & bus.mem_rdata_valid;
        data_rdata_valid = (owner == DATA) & bus.mem_rdata_valid;
      end
      default: ;
    endcase
  end

  assign bus.mem_req_valid    = mem_req_valid;
  assign bus.mem_rdata_ack    = mem_rdata_ack;
  assign bus.inst_req_ack     = inst_req_ack;
  assign bus.data_req_ack     = data_req_ack;
  assign bus.inst_rdata_valid = inst_rdata_valid;
  assign bus.data_rdata_valid = data_rdata_valid;
  assign bus.inst_rdata       = bus.mem_rdata;
  assign bus.data_rdata       = bus.mem_rdata;
  assign bus.mem_wen          = wen_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_wdata        = wdata_q;
  assign bus.mem_wstrb        = wstrb_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.inst_req_valid = 0; bus.inst_addr = '0; bus.inst_rdata_ack = 0;
    bus.data_rd = 0; bus.data_wr = 0; bus.data_addr = '0; bus.data_wdata = '0;
    bus.data_wstrb = '0; bus.data_rdata_ack = 0;
    bus.mem_req_ack = 0; bus.mem_rdata = '0; bus.mem_rdata_valid = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // called at a negedge while in REQ; returns at a negedge in IDLE
  task automatic complete_read(input bit side);
    bus.mem_req_ack = 1;
    @(negedge clk);
    bus.mem_req_ack = 0;
    if (side) begin bus.data_rd = 0; bus.data_wr = 0; end
    else bus.inst_req_valid = 0;
    bus.mem_rdata_valid = 1; bus.inst_rdata_ack = 1; bus.data_rdata_ack = 1;
    @(negedge clk);
    bus.mem_rdata_valid = 0; bus.inst_rdata_ack = 0; bus.data_rdata_ack = 0;
  endtask

  task automatic test_reset();
    logic [5:0] hs;
    logic [31:0] rv;
    rst = 1'b0;
    clear_inputs();
    rv = 32'h1234_5678;
    bus.inst_req_valid = 1; bus.data_wr = 1; bus.mem_req_ack = 1;
    bus.mem_rdata_valid = 1; bus.mem_rdata = rv; bus.inst_rdata_ack = 1; bus.data_rdata_ack = 1;
    repeat (2) @(negedge clk);
    #1;
    hs = {bus.mem_req_valid, bus.mem_rdata_ack, bus.inst_req_ack, bus.data_req_ack, bus.inst_rdata_valid, bus.data_rdata_valid};
    checks++; if (hs !== 6'b0) begin errors++; $display("FAIL reset_handshakes: got %b want 000000", hs); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if ({bus.mem_wen, bus.mem_wstrb} !== 5'b0) begin errors++; $display("FAIL reset_wen_wstrb: got %b want 00000", {bus.mem_wen, bus.mem_wstrb}); end
    checks++; if (bus.inst_rdata !== rv || bus.data_rdata !== rv) begin errors++; $display("FAIL rdata_passthrough: got %h/%h want %h", bus.inst_rdata, bus.data_rdata, rv); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    bus.inst_req_valid = 1; bus.inst_addr = 32'h40;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_no_zero_latency: got %b want 0", bus.mem_req_valid); end
    @(negedge clk);
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_wen !== 1'b0 || bus.mem_wstrb !== 4'h0)
      begin errors++; $display("FAIL fetch_req: got v=%b a=%h w=%b s=%h want v=1 a=40 w=0 s=0", bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wstrb); end
    checks++; if (bus.inst_req_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_early: got %b want 0", bus.inst_req_ack); end
    @(negedge clk);
    bus.mem_req_ack = 1;
    #1;
    checks++; if (bus.inst_req_ack !== 1'b1 || bus.data_req_ack !== 1'b0) begin errors++; $display("FAIL fetch_req_ack: got i=%b d=%b want i=1 d=0", bus.inst_req_ack, bus.data_req_ack); end
    @(negedge clk);
    bus.mem_req_ack = 0; bus.inst_req_valid = 0; bus.inst_addr = 32'hFFFF_0000;
    bus.mem_rdata = 32'h8C01_0004; bus.mem_rdata_valid = 1; bus.inst_rdata_ack = 1;
    #1;
    checks++; if (bus.inst_rdata_valid !== 1'b1 || bus.inst_rdata !== 32'h8C01_0004 || bus.data_rdata_valid !== 1'b0 || bus.mem_rdata_ack !== 1'b1)
      begin errors++; $display("FAIL fetch_resp: got iv=%b d=%h dv=%b ack=%b want iv=1 d=8c010004 dv=0 ack=1", bus.inst_rdata_valid, bus.inst_rdata, bus.data_rdata_valid, bus.mem_rdata_ack); end
    @(negedge clk);
    checks++; if ({bus.mem_req_valid, bus.mem_rdata_ack, bus.inst_rdata_valid} !== 3'b0) begin errors++; $display("FAIL fetch_back_idle: got %b want 000", {bus.mem_req_valid, bus.mem_rdata_ack, bus.inst_rdata_valid}); end
    clear_inputs();
  endtask

  task automatic test_store();
    @(negedge clk);
    bus.data_wr = 1; bus.data_addr = 32'h104; bus.data_wdata = 32'hDEAD_BEEF; bus.data_wstrb = 4'b0011;
    @(negedge clk);
    checks++; if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 32'h104 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wstrb !== 4'b0011 || bus.data_req_ack !== 1'b0)
      begin errors++; $display("FAIL store_fields: got w=%b a=%h d=%h s=%b ack=%b", bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.data_req_ack); end
    bus.data_addr = 32'h999; bus.data_wdata = 32'h1111_2222; bus.data_wstrb = 4'b1100;
    @(negedge clk);
    checks++; if (bus.mem_addr !== 32'h104 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wstrb !== 4'b0011)
      begin errors++; $display("FAIL store_latched: got a=%h d=%h s=%b want a=104 d=deadbeef s=0011", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); end
    bus.mem_req_ack = 1;
    #1;
    checks++; if (bus.data_req_ack !== 1'b1 || bus.inst_req_ack !== 1'b0) begin errors++; $display("FAIL store_ack: got d=%b i=%b want d=1 i=0", bus.data_req_ack, bus.inst_req_ack); end
    @(negedge clk);
    bus.mem_req_ack = 0; bus.data_wr = 0; bus.mem_rdata_valid = 1; bus.data_rdata_ack = 1;
    #1;
    checks++; if ({bus.mem_req_valid, bus.mem_rdata_ack, bus.data_rdata_valid} !== 3'b0) begin errors++; $display("FAIL store_no_resp: got %b want 000", {bus.mem_req_valid, bus.mem_rdata_ack, bus.data_rdata_valid}); end
    clear_inputs();
  endtask

  task automatic test_tie();
    apply_reset();
    bus.inst_req_valid = 1; bus.inst_addr = 32'hA1;
    bus.data_rd = 1; bus.data_addr = 32'hD1;
    @(negedge clk);
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'hA1) begin errors++; $display("FAIL tie1_inst: got v=%b a=%h want v=1 a=a1", bus.mem_req_valid, bus.mem_addr); end
    complete_read(1'b0);
    bus.inst_req_valid = 1; bus.inst_addr = 32'hA2;
    @(negedge clk);
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'hD1) begin errors++; $display("FAIL tie2_data: got v=%b a=%h want v=1 a=d1", bus.mem_req_valid, bus.mem_addr); end
    complete_read(1'b1);
    bus.data_rd = 1; bus.data_addr = 32'hD2;
    @(negedge clk);
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'hA2) begin errors++; $display("FAIL tie3_inst: got v=%b a=%h want v=1 a=a2", bus.mem_req_valid, bus.mem_addr); end
    complete_read(1'b0);
    clear_inputs();
  endtask

  task automatic test_load_stall();
    @(negedge clk);
    bus.data_rd = 1; bus.data_addr = 32'h200;
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.mem_req_valid !== 1'b1 || bus.data_req_ack !== 1'b0) begin errors++; $display("FAIL load_req_stall: got v=%b ack=%b want v=1 ack=0", bus.mem_req_valid, bus.data_req_ack); end
    end
    bus.mem_req_ack = 1;
    @(negedge clk);
    bus.mem_req_ack = 0; bus.data_rd = 0;
    bus.mem_rdata = 32'hCAFE_F00D; bus.mem_rdata_valid = 1; bus.data_rdata_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.data_rdata_valid !== 1'b1 || bus.mem_rdata_ack !== 1'b0 || bus.inst_rdata_valid !== 1'b0 || bus.data_rdata !== 32'hCAFE_F00D)
        begin errors++; $display("FAIL load_resp_stall%0d: got dv=%b ack=%b iv=%b d=%h", i, bus.data_rdata_valid, bus.mem_rdata_ack, bus.inst_rdata_valid, bus.data_rdata); end
      @(negedge clk);
    end
    bus.data_rdata_ack = 1;
    #1;
    checks++; if (bus.mem_rdata_ack !== 1'b1 || bus.data_rdata_valid !== 1'b1) begin errors++; $display("FAIL load_resp_ack: got ack=%b dv=%b want 1 1", bus.mem_rdata_ack, bus.data_rdata_valid); end
    @(negedge clk);
    checks++; if (bus.data_rdata_valid !== 1'b0 || bus.mem_rdata_ack !== 1'b0) begin errors++; $display("FAIL load_back_idle: got dv=%b ack=%b want 0 0", bus.data_rdata_valid, bus.mem_rdata_ack); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_resp();
    logic [5:0] hs;
    @(negedge clk);
    bus.data_rd = 1; bus.data_addr = 32'h300;
    @(negedge clk);
    bus.mem_req_ack = 1;
    @(negedge clk);
    bus.mem_req_ack = 0; bus.data_rd = 0; bus.mem_rdata_valid = 1; bus.data_rdata_ack = 1;
    bus.inst_rdata_ack = 1; bus.mem_req_ack = 1;
    #1;
    checks++; if (bus.data_rdata_valid !== 1'b1) begin errors++; $display("FAIL mid_resp_pre: got %b want 1", bus.data_rdata_valid); end
    #1 rst = 1'b0;
    #1;
    hs = {bus.mem_req_valid, bus.mem_rdata_ack, bus.inst_req_ack, bus.data_req_ack, bus.inst_rdata_valid, bus.data_rdata_valid};
    checks++; if (hs !== 6'b0) begin errors++; $display("FAIL mid_resp_reset: got %b want 000000", hs); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    bus.inst_req_valid = 1; bus.inst_addr = 32'h0;
    @(negedge clk);
    checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_wen !== 1'b0) begin errors++; $display("FAIL post_reset_fetch: got v=%b a=%h w=%b want 1 0 0", bus.mem_req_valid, bus.mem_addr, bus.mem_wen); end
    bus.mem_req_ack = 1;
    @(negedge clk);
    bus.mem_req_ack = 0; bus.inst_req_valid = 0; bus.mem_rdata = 32'h0000_0013; bus.mem_rdata_valid = 1; bus.inst_rdata_ack = 1;
    #1;
    checks++; if (bus.inst_rdata_valid !== 1'b1 || bus.inst_rdata !== 32'h13 || bus.mem_rdata_ack !== 1'b1) begin errors++; $display("FAIL post_reset_resp: got iv=%b d=%h ack=%b", bus.inst_rdata_valid, bus.inst_rdata, bus.mem_rdata_ack); end
    @(negedge clk);
    clear_inputs();
  endtask

  // Transaction-level model: pending requests per side, round-robin on the
  // last winner, fields captured when the port is granted.
  task automatic test_random();
    bit ipend = 0, dpend = 0, drd = 0, dwr = 0, last_data = 1, own = 0, own_ack;
    logic [31:0] iaddr = '0, daddr = '0, dwdata = '0;
    logic [3:0] dwstrb = '0;
    bit e_wen = 0;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic [3:0] e_wstrb = '0;
    int phase = 0, txns = 0, kind;
    logic [7:0] idle_out;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!ipend && $urandom_range(0, 2) == 0) begin ipend = 1; iaddr = $urandom; end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1; daddr = $urandom; dwdata = $urandom; dwstrb = 4'($urandom);
        kind = $urandom_range(0, 2); drd = (kind != 1); dwr = (kind != 0);
      end
      bus.inst_req_valid = ipend;
      bus.inst_addr = (phase != 0 && !own) ? 32'($urandom) : iaddr;
      bus.data_rd = dpend & drd; bus.data_wr = dpend & dwr;
      bus.data_addr  = (phase != 0 && own) ? 32'($urandom) : daddr;
      bus.data_wdata = (phase != 0 && own) ? 32'($urandom) : dwdata;
      bus.data_wstrb = (phase != 0 && own) ? 4'($urandom) : dwstrb;
      bus.mem_req_ack = 1'($urandom); bus.mem_rdata_valid = 1'($urandom); bus.mem_rdata = $urandom;
      bus.inst_rdata_ack = 1'($urandom); bus.data_rdata_ack = 1'($urandom);
      #1;
      if (phase == 0) begin
        idle_out = {bus.mem_req_valid, bus.mem_rdata_ack, bus.inst_req_ack, bus.data_req_ack, bus.inst_rdata_valid, bus.data_rdata_valid, 2'b00};
        checks++; if (idle_out !== 8'h0) begin errors++; $display("FAIL rnd_idle cyc%0d: got %b want 0", cyc, idle_out); end
        if (ipend || dpend) begin
          own = dpend && (!ipend || !last_data);
          last_data = own;
          e_wen   = own ? dwr : 1'b0;
          e_addr  = own ? daddr : iaddr;
          e_wdata = own ? dwdata : 32'h0;
          e_wstrb = (own && dwr) ? dwstrb : 4'h0;
          phase = 1;
        end
      end else if (phase == 1) begin
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_wen !== e_wen || bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata || bus.mem_wstrb !== e_wstrb)
          begin errors++; $display("FAIL rnd_req cyc%0d: got v=%b w=%b a=%h d=%h s=%h want v=1 w=%b a=%h d=%h s=%h", cyc, bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, e_wen, e_addr, e_wdata, e_wstrb); end
        checks++; if (bus.inst_req_ack !== (!own && bus.mem_req_ack) || bus.data_req_ack !== (own && bus.mem_req_ack) || bus.mem_rdata_ack !== 1'b0 || bus.inst_rdata_valid !== 1'b0 || bus.data_rdata_valid !== 1'b0)
          begin errors++; $display("FAIL rnd_req_hs cyc%0d: got ia=%b da=%b ra=%b iv=%b dv=%b own=%b", cyc, bus.inst_req_ack, bus.data_req_ack, bus.mem_rdata_ack, bus.inst_rdata_valid, bus.data_rdata_valid, own); end
        if (bus.mem_req_ack) begin
          if (own) dpend = 0; else ipend = 0;
          phase = e_wen ? 0 : 2;
          if (e_wen) txns++;
        end
      end else begin
        own_ack = own ? bus.data_rdata_ack : bus.inst_rdata_ack;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.mem_rdata_ack !== own_ack || bus.inst_rdata_valid !== (!own && bus.mem_rdata_valid) || bus.data_rdata_valid !== (own && bus.mem_rdata_valid))
          begin errors++; $display("FAIL rnd_resp cyc%0d: got v=%b ra=%b iv=%b dv=%b own=%b", cyc, bus.mem_req_valid, bus.mem_rdata_ack, bus.inst_rdata_valid, bus.data_rdata_valid, own); end
        checks++; if (bus.inst_rdata !== bus.mem_rdata || bus.data_rdata !== bus.mem_rdata) begin errors++; $display("FAIL rnd_rdata cyc%0d: got %h/%h", cyc, bus.inst_rdata, bus.data_rdata); end
        if (bus.mem_rdata_valid && own_ack) begin phase = 0; txns++; end
      end
    end
    checks++; if (txns < 100) begin errors++; $display("FAIL rnd_progress: got %0d transactions want >= 100", txns); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_tie();
    test_load_stall();
    test_reset_mid_resp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
